pipeline_stage_memory: RTL and testbench

Fourth pipeline stage, directly downstream of the execution stage. Takes the execution stage's registered result, performs the data-memory load or store over a req/ack bus, and registers the result for write-back. Also publishes its registered result as forwarding data for hazard resolution, and stalls upstream while a bus access is outstanding.

---
 rtl/pipeline_stage_memory_if.sv | 33 +++
 rtl/pipeline_stage_memory.sv | 223 ++++++++++++++++++++++
 tb/tb_pipeline_stage_memory.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_memory_if.sv
// Data-memory req/ack bus between the memory pipeline stage (master) and the data memory (slave).
// Request-side signals are held stable from request until the ack is sampled.
interface pipeline_stage_memory_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      memReq;
    logic                      memWrite;
    logic [DATA_WIDTH-1:0]     memAddr;
    logic [DATA_WIDTH-1:0]     memWdata;
    logic [DATA_WIDTH/8-1:0]   memWstrb;
    logic [DATA_WIDTH-1:0]     memRdata;
    logic                      memAck;

    modport master (
        output memReq,
        output memWrite,
        output memAddr,
        output memWdata,
        output memWstrb,
        input  memRdata,
        input  memAck
    );

    modport slave (
        input  memReq,
        input  memWrite,
        input  memAddr,
        input  memWdata,
        input  memWstrb,
        output memRdata,
        output memAck
    );
endinterface

// File: rtl/pipeline_stage_memory.sv
// Memory pipeline stage: performs loads/stores over a req/ack bus and registers the write-back result.
// Upstream is stalled while an access is outstanding; the ex* inputs are held stable during a stall.
module pipeline_stage_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ID_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      exBubbled,
    input  logic                      exRegWriteEnabled,
    input  logic [REG_ID_WIDTH-1:0]   exRegWriteId,
    input  logic                      exRegDataWriteReady,
    input  logic [DATA_WIDTH-1:0]     exRegDataWrite,
    input  logic [DATA_WIDTH-1:0]     exAluResult,
    input  logic [DATA_WIDTH-1:0]     exStoreData,
    input  logic                      exMemRead,
    input  logic                      exMemWrite,
    input  logic [1:0]                exMemSize,
    input  logic                      exLoadSigned,
    pipeline_stage_memory_if.master   memBus,
    output logic                      stallFromMemory,
    output logic                      misalignedError,
    output logic                      wbBubbled,
    output logic                      wbRegWriteEnabled,
    output logic [REG_ID_WIDTH-1:0]   wbRegWriteId,
    output logic [DATA_WIDTH-1:0]     wbRegData,
    output logic [REG_ID_WIDTH-1:0]   fwdRegisterId,
    output logic                      fwdDataReady,
    output logic [DATA_WIDTH-1:0]     fwdData
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } stateType;

    stateType                  stateReg;
    stateType                  stateNext;

    logic                      memAccess;
    logic                      accessAligned;
    logic                      memOp;
    logic                      misaligned;
    logic                      inAccess;
    logic [DATA_WIDTH-1:0]     passData;

    logic                      wbBubbledNext;
    logic                      wbRegWriteEnabledNext;
    logic [REG_ID_WIDTH-1:0]   wbRegWriteIdNext;
    logic [DATA_WIDTH-1:0]     wbRegDataNext;
    logic                      misalignedErrorNext;

    // Size encoding 3 is illegal and behaves as a word access everywhere below.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] addrLow);
        logic result;
        case (size)
            2'd0:    result = 1'b1;
            2'd1:    result = (addrLow[0] == 1'b0);
            default: result = (addrLow == 2'b00);
        endcase
        return result;
    endfunction

    function automatic logic [3:0] storeStrobe(input logic [1:0] size, input logic [1:0] addrLow);
        logic [3:0] result;
        case (size)
            2'd0:    result = 4'b0001 << addrLow;
            2'd1:    result = 4'b0011 << addrLow;
            default: result = 4'b1111;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] storeLanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] result;
        case (size)
            2'd0:    result = {4{data[7:0]}};
            2'd1:    result = {2{data[15:0]}};
            default: result = data;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] loadExtract(input logic [1:0]  size,
                                                input logic        signExtend,
                                                input logic [1:0]  addrLow,
                                                input logic [31:0] rdata);
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        logic [31:0] result;
        byteVal = rdata[{addrLow, 3'b000} +: 8];
        halfVal = addrLow[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    result = signExtend ? {{24{byteVal[7]}}, byteVal} : {24'd0, byteVal};
            2'd1:    result = signExtend ? {{16{halfVal[15]}}, halfVal} : {16'd0, halfVal};
            default: result = rdata;
        endcase
        return result;
    endfunction

    // Classify the presented instruction.
    always_comb begin
        memAccess     = !exBubbled && (exMemRead || exMemWrite);
        accessAligned = isAligned(exMemSize, exAluResult[1:0]);
        memOp         = memAccess && accessAligned;
        misaligned    = memAccess && !accessAligned;
        inAccess      = (stateReg == ACCESS);
        passData      = exRegDataWriteReady ? exRegDataWrite : exAluResult;
    end

    // Bus outputs come only from the state register and the held ex* inputs.
    always_comb begin
        memBus.memReq   = 1'b0;
        memBus.memWrite = 1'b0;
        memBus.memAddr  = {exAluResult[DATA_WIDTH-1:2], 2'b00};
        memBus.memWdata = storeLanes(exMemSize, exStoreData);
        memBus.memWstrb = 4'b0000;
        if (inAccess) begin
            memBus.memReq   = 1'b1;
            memBus.memWrite = exMemWrite;
            memBus.memWstrb = exMemWrite ? storeStrobe(exMemSize, exAluResult[1:0]) : 4'b0000;
        end else begin
            memBus.memReq   = 1'b0;
            memBus.memWrite = 1'b0;
            memBus.memWstrb = 4'b0000;
        end
    end

    // Next state and upstream stall.
    always_comb begin
        stateNext       = stateReg;
        stallFromMemory = 1'b0;
        case (stateReg)
            IDLE: begin
                if (memOp) begin
                    stateNext       = ACCESS;
                    stallFromMemory = 1'b1;
                end else begin
                    stateNext       = IDLE;
                    stallFromMemory = 1'b0;
                end
            end
            ACCESS: begin
                if (memBus.memAck) begin
                    stateNext       = IDLE;
                    stallFromMemory = 1'b0;
                end else begin
                    stateNext       = ACCESS;
                    stallFromMemory = 1'b1;
                end
            end
            default: begin
                stateNext       = IDLE;
                stallFromMemory = 1'b0;
            end
        endcase
    end

    // Write-back result; stalled cycles register a bubble so no instruction is seen twice.
    always_comb begin
        wbBubbledNext         = 1'b1;
        wbRegWriteEnabledNext = 1'b0;
        wbRegWriteIdNext      = {REG_ID_WIDTH{1'b0}};
        wbRegDataNext         = {DATA_WIDTH{1'b0}};
        misalignedErrorNext   = (stateReg == IDLE) && misaligned;
        if (stallFromMemory) begin
            wbBubbledNext = 1'b1;
        end else if (inAccess) begin
            wbBubbledNext         = 1'b0;
            wbRegWriteEnabledNext = exRegWriteEnabled;
            wbRegWriteIdNext      = exRegWriteId;
            wbRegDataNext         = exMemRead
                                  ? loadExtract(exMemSize, exLoadSigned, exAluResult[1:0], memBus.memRdata)
                                  : passData;
        end else if (exBubbled || misaligned) begin
            wbBubbledNext = 1'b1;
        end else begin
            wbBubbledNext         = 1'b0;
            wbRegWriteEnabledNext = exRegWriteEnabled;
            wbRegWriteIdNext      = exRegWriteId;
            wbRegDataNext         = passData;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Write-back and error registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wbBubbled         <= 1'b1;
            wbRegWriteEnabled <= 1'b0;
            wbRegWriteId      <= {REG_ID_WIDTH{1'b0}};
            wbRegData         <= {DATA_WIDTH{1'b0}};
            misalignedError   <= 1'b0;
        end else begin
            wbBubbled         <= wbBubbledNext;
            wbRegWriteEnabled <= wbRegWriteEnabledNext;
            wbRegWriteId      <= wbRegWriteIdNext;
            wbRegData         <= wbRegDataNext;
            misalignedError   <= misalignedErrorNext;
        end
    end

    // Forwarding view of the registered result; this stage's results are always final.
    always_comb begin
        fwdDataReady = 1'b1;
        if (wbBubbled || !wbRegWriteEnabled) begin
            fwdRegisterId = {REG_ID_WIDTH{1'b0}};
            fwdData       = {DATA_WIDTH{1'b0}};
        end else begin
            fwdRegisterId = wbRegWriteId;
            fwdData       = wbRegData;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_memory.sv
// Randomized bench for pipeline_stage_memory against a byte-addressed reference memory model.
module tb_pipeline_stage_memory;

    typedef struct {
        logic        bub;
        logic        regWe;
        logic [4:0]  regId;
        logic        ready;
        logic [31:0] regData;
        logic [31:0] alu;
        logic [31:0] storeData;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        int          ackDelay;
    } instrT;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exBubbled = 1'b1;
    logic        exRegWriteEnabled = 1'b0;
    logic [4:0]  exRegWriteId = 5'd0;
    logic        exRegDataWriteReady = 1'b0;
    logic [31:0] exRegDataWrite = 32'd0;
    logic [31:0] exAluResult = 32'd0;
    logic [31:0] exStoreData = 32'd0;
    logic        exMemRead = 1'b0;
    logic        exMemWrite = 1'b0;
    logic [1:0]  exMemSize = 2'd0;
    logic        exLoadSigned = 1'b0;
    logic        stallFromMemory;
    logic        misalignedError;
    logic        wbBubbled;
    logic        wbRegWriteEnabled;
    logic [4:0]  wbRegWriteId;
    logic [31:0] wbRegData;
    logic [4:0]  fwdRegisterId;
    logic        fwdDataReady;
    logic [31:0] fwdData;

    pipeline_stage_memory_if bus ();

    pipeline_stage_memory dut (
        .clock               (clock),
        .reset               (reset),
        .exBubbled           (exBubbled),
        .exRegWriteEnabled   (exRegWriteEnabled),
        .exRegWriteId        (exRegWriteId),
        .exRegDataWriteReady (exRegDataWriteReady),
        .exRegDataWrite      (exRegDataWrite),
        .exAluResult         (exAluResult),
        .exStoreData         (exStoreData),
        .exMemRead           (exMemRead),
        .exMemWrite          (exMemWrite),
        .exMemSize           (exMemSize),
        .exLoadSigned        (exLoadSigned),
        .memBus              (bus.master),
        .stallFromMemory     (stallFromMemory),
        .misalignedError     (misalignedError),
        .wbBubbled           (wbBubbled),
        .wbRegWriteEnabled   (wbRegWriteEnabled),
        .wbRegWriteId        (wbRegWriteId),
        .wbRegData           (wbRegData),
        .fwdRegisterId       (fwdRegisterId),
        .fwdDataReady        (fwdDataReady),
        .fwdData             (fwdData)
    );

    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] refMem [0:4095];
    logic [7:0] busMem [0:4095];

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int numBytes(input logic [1:0] size);
        case (size)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        int nb = numBytes(size);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(refMem[int'(addr[11:0]) + i]) << (8 * i));
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] busWord(input logic [31:0] addr);
        int base = int'(addr[11:0]) & ~3;
        return {busMem[base + 3], busMem[base + 2], busMem[base + 1], busMem[base]};
    endfunction

    // Presents one instruction, plays the memory side, and checks the registered result.
    task automatic runInstr(input instrT ins, output int reqStart);
        int nb, base, stallCycles;
        logic isMem, memOp, mis, expBubble;
        logic [31:0] expData, expStrb, expWdata, storeVal;
        exBubbled = ins.bub; exRegWriteEnabled = ins.regWe; exRegWriteId = ins.regId;
        exRegDataWriteReady = ins.ready; exRegDataWrite = ins.regData; exAluResult = ins.alu;
        exStoreData = ins.storeData; exMemRead = ins.rd; exMemWrite = ins.wr;
        exMemSize = ins.size; exLoadSigned = ins.sgn;
        nb = numBytes(ins.size);
        base = int'(ins.alu[11:0]) & ~3;
        isMem = !ins.bub && (ins.rd || ins.wr);
        memOp = isMem && ((int'(ins.alu[11:0]) % nb) == 0);
        mis = isMem && !memOp;
        expData = (memOp && ins.rd) ? refLoad(ins.alu, ins.size, ins.sgn)
                                    : (ins.ready ? ins.regData : ins.alu);
        reqStart = -1;
        bus.memAck = isMem ? 1'b0 : 1'($urandom_range(0, 1));
        bus.memRdata = $urandom;
        #1;
        checkValue("stall_idle", stallFromMemory, memOp);
        checkValue("req_idle", bus.memReq, 1'b0);
        @(posedge clock); #1;
        bus.memAck = 1'b0;
        if (memOp) begin
            stallCycles = 1;
            reqStart = cycle;
            checkValue("mis_err_access", misalignedError, 1'b0);
            for (int k = 0; k <= ins.ackDelay; k++) begin
                checkValue("wb_bubble_stall", wbBubbled, 1'b1);
                checkValue("req_access", bus.memReq, 1'b1);
                checkValue("addr", bus.memAddr, {ins.alu[31:2], 2'b00});
                checkValue("write", bus.memWrite, ins.wr);
                if (ins.wr) begin
                    expStrb = 32'd0;
                    expWdata = 32'd0;
                    storeVal = ins.storeData;
                    for (int i = 0; i < 4; i++) begin
                        if (base + i >= int'(ins.alu[11:0]) && base + i < int'(ins.alu[11:0]) + nb)
                            expStrb[i] = 1'b1;
                        expWdata[8 * i +: 8] = storeVal[8 * (i % nb) +: 8];
                    end
                    checkValue("wstrb", 32'(bus.memWstrb), expStrb);
                    checkValue("wdata", bus.memWdata, expWdata);
                end
                if (k == ins.ackDelay) begin
                    bus.memAck = 1'b1;
                    bus.memRdata = busWord(ins.alu);
                    if (ins.wr) begin
                        for (int i = 0; i < 4; i++)
                            if (bus.memWstrb[i]) busMem[base + i] = bus.memWdata[8 * i +: 8];
                        for (int i = 0; i < nb; i++)
                            refMem[int'(ins.alu[11:0]) + i] = storeVal[8 * i +: 8];
                    end
                    #1;
                    checkValue("stall_ack", stallFromMemory, 1'b0);
                end else begin
                    bus.memRdata = $urandom;
                    #1;
                    checkValue("stall_wait", stallFromMemory, 1'b1);
                    stallCycles++;
                end
                @(posedge clock); #1;
            end
            bus.memAck = 1'b0;
            checkValue("req_drop", bus.memReq, 1'b0);
            checkValue("stall_len", 32'(stallCycles), 32'(ins.ackDelay + 1));
        end
        expBubble = ins.bub || mis;
        checkValue("mis_err", misalignedError, mis);
        checkValue("wb_bubbled", wbBubbled, expBubble);
        checkValue("fwd_ready", fwdDataReady, 1'b1);
        if (!expBubble) begin
            checkValue("wb_we", wbRegWriteEnabled, ins.regWe);
            checkValue("wb_id", 32'(wbRegWriteId), 32'(ins.regId));
            if (ins.regWe) checkValue("wb_data", wbRegData, expData);
            checkValue("fwd_id", 32'(fwdRegisterId), ins.regWe ? 32'(ins.regId) : 32'd0);
            checkValue("fwd_data", fwdData, ins.regWe ? expData : 32'd0);
        end else begin
            checkValue("fwd_id_bubble", 32'(fwdRegisterId), 32'd0);
            checkValue("fwd_data_bubble", fwdData, 32'd0);
        end
    endtask

    function automatic instrT mkInstr(input logic rd, input logic wr, input logic [1:0] size,
                                      input logic [31:0] alu, input int ackDelay);
        instrT ins;
        ins.bub = 1'b0; ins.regWe = !wr; ins.regId = 5'($urandom_range(1, 31));
        ins.ready = 1'b0; ins.regData = $urandom; ins.alu = alu; ins.storeData = $urandom;
        ins.rd = rd; ins.wr = wr; ins.size = size; ins.sgn = 1'b0; ins.ackDelay = ackDelay;
        return ins;
    endfunction

    initial begin
        instrT ins;
        int start1, start2, dummy;
        bus.memAck = 1'b0;
        bus.memRdata = 32'd0;
        for (int i = 0; i < 4096; i++) begin
            refMem[i] = 8'($urandom);
            busMem[i] = refMem[i];
        end
        {refMem[259], refMem[258], refMem[257], refMem[256]} = 32'h80FF_FF7F;
        {busMem[259], busMem[258], busMem[257], busMem[256]} = 32'h80FF_FF7F;

        #12;
        checkValue("rst_req", bus.memReq, 1'b0);
        checkValue("rst_wstrb", 32'(bus.memWstrb), 32'd0);
        checkValue("rst_wb_bubbled", wbBubbled, 1'b1);
        checkValue("rst_wb_we", wbRegWriteEnabled, 1'b0);
        checkValue("rst_wb_id", 32'(wbRegWriteId), 32'd0);
        checkValue("rst_wb_data", wbRegData, 32'd0);
        checkValue("rst_mis_err", misalignedError, 1'b0);
        checkValue("rst_fwd_id", 32'(fwdRegisterId), 32'd0);
        checkValue("rst_fwd_ready", fwdDataReady, 1'b1);
        checkValue("rst_fwd_data", fwdData, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // ALU op writing r3
        ins = mkInstr(1'b0, 1'b0, 2'd2, 32'h0000_5555, 0);
        ins.regId = 5'd3; ins.ready = 1'b1; ins.regData = 32'h0000_1234;
        runInstr(ins, dummy);
        // signed byte load at 0x103, ack three cycles after the request
        ins = mkInstr(1'b1, 1'b0, 2'd0, 32'h0000_0103, 3);
        ins.sgn = 1'b1;
        runInstr(ins, dummy);
        checkValue("signed_byte_load", wbRegData, 32'hFFFF_FF80);
        // half store at 0x202
        ins = mkInstr(1'b0, 1'b1, 2'd1, 32'h0000_0202, 0);
        ins.storeData = 32'h0000_ABCD;
        runInstr(ins, dummy);
        // misaligned word load
        runInstr(mkInstr(1'b1, 1'b0, 2'd2, 32'h0000_0101, 0), dummy);
        // back-to-back word loads
        runInstr(mkInstr(1'b1, 1'b0, 2'd2, 32'h0000_0300, 1), start1);
        runInstr(mkInstr(1'b1, 1'b0, 2'd2, 32'h0000_0304, 1), start2);
        checkValue("b2b_req_gap", 32'(start2 - start1), 32'd3);

        // reset in the middle of an access
        ins = mkInstr(1'b1, 1'b0, 2'd2, 32'h0000_0400, 0);
        exBubbled = 1'b0; exMemRead = 1'b1; exMemWrite = 1'b0; exMemSize = 2'd2;
        exAluResult = ins.alu; exRegWriteEnabled = 1'b1; exRegWriteId = 5'd7;
        bus.memAck = 1'b0;
        @(posedge clock); #1;
        checkValue("req_before_reset", bus.memReq, 1'b1);
        reset = 1'b0;
        #1;
        checkValue("req_async_reset", bus.memReq, 1'b0);
        checkValue("wb_bubbled_reset", wbBubbled, 1'b1);
        checkValue("fwd_id_reset", 32'(fwdRegisterId), 32'd0);
        exBubbled = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        bus.memAck = 1'b1;
        bus.memRdata = 32'hDEAD_BEEF;
        #1;
        checkValue("late_ack_req", bus.memReq, 1'b0);
        checkValue("late_ack_stall", stallFromMemory, 1'b0);
        @(posedge clock); #1;
        bus.memAck = 1'b0;
        checkValue("late_ack_wb", wbBubbled, 1'b1);
        checkValue("late_ack_fwd", fwdData, 32'd0);

        // randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            int kind = $urandom_range(0, 3);
            ins.bub = ($urandom_range(0, 7) == 0);
            ins.regWe = 1'($urandom_range(0, 1));
            ins.regId = 5'($urandom);
            ins.ready = 1'($urandom_range(0, 1));
            ins.regData = $urandom;
            ins.storeData = $urandom;
            ins.rd = (kind == 2);
            ins.wr = (kind == 3);
            ins.size = 2'($urandom_range(0, 3));
            ins.sgn = 1'($urandom_range(0, 1));
            ins.ackDelay = $urandom_range(0, 3);
            ins.alu = (kind >= 2) ? {20'd0, 12'($urandom)} : $urandom;
            runInstr(ins, dummy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
